uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
16x-oversampled UART receiver for the UART path.
- Consumes os_tick from the baud generator and recovers 8N1 frames from the asynchronous rx pin.
- Validates the start bit at mid-bit and samples data bits at bit centres.
- Checks the stop bit and emits one byte per valid frame, or a framing-error pulse.
- Feeds the command/byte parser downstream.

Parameters:
DATA_BITS, 8, data bits per frame (LSB first), 5..9 supported
OS, 16, oversampling ratio; must equal the baud generator's OS; even, >= 4

Ports:
CLK  input  1  system clock
rst  input  1  synchronous, active-high reset
os_tick  input  1  one-CLK pulse at OS x baud rate, from baud generator
rx  input  1  asynchronous serial line, idle high
rx_data  output  DATA_BITS  last correctly received byte; holds until next valid frame
rx_valid  output  1  one-CLK pulse: rx_data updated this cycle
frame_err  output  1  one-CLK pulse: stop bit sampled low
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset: clock CLK; reset rst, synchronous, active-high.
  - Reset values: rx_data=0, rx_valid=0, frame_err=0, busy=0, state=IDLE.
  - Reset values (internal): os_cnt=0, bit_idx=0, shift reg=0, both synchronizer flops=1.
  - rst wins over every other event, including mid-frame; the partial frame is discarded with no pulse.
- Synchronizer: rx passes through a 2-FF synchronizer; rx_s denotes its output. All decisions use rx_s.
- Tick gating: state, os_cnt and bit_idx change only on cycles with os_tick=1. rx activity without os_tick has no effect.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: on os_tick with rx_s=0 -> START, os_cnt=0.
- START: on os_tick:
  - If os_cnt != OS/2-1, increment os_cnt.
  - Otherwise (mid start bit): if rx_s=0 -> DATA, os_cnt=0, bit_idx=0; else -> IDLE (glitch rejected, no output pulse).
- DATA: on os_tick:
  - If os_cnt != OS-1, increment os_cnt.
  - Otherwise: shift rx_s in at the MSB (right shift, LSB-first line order) and set os_cnt=0.
  - Then: if bit_idx=DATA_BITS-1 -> STOP; else bit_idx+1.
- STOP: on os_tick:
  - If os_cnt != OS-1, increment os_cnt.
  - Otherwise, if rx_s=1: rx_data<=shift, rx_valid=1 for exactly one CLK, -> IDLE.
  - Otherwise: frame_err=1 for one CLK, rx_data unchanged, -> BREAK.
- BREAK: on os_tick with rx_s=1 -> IDLE. A held-low line never re-triggers START.
- Latency: rx_valid/frame_err are registered and assert in the CLK cycle after the os_tick that samples the stop bit. They are never both high.
- Back-to-back frames: a start bit immediately following a stop bit is detected on the first os_tick after returning to IDLE.
- Counter widths: os_cnt = clog2(OS) bits; bit_idx = clog2(DATA_BITS) bits (min 1). No wrap beyond the compare values.

Test Plan:
1. Bench drives os_tick every 4 CLK, OS=16, line frame 0x55 with 16 ticks/bit -> single rx_valid pulse, rx_data=0x55, frame_err never high, busy falls after the stop bit.
2. Frames 0xA3 then 0x0F with zero idle gap -> two rx_valid pulses in order, rx_data=0xA3 then 0x0F, no frame_err.
3. rx low for 4 os_ticks then high -> no rx_valid/frame_err; busy high ~9 ticks then returns to 0; a following 0x7E frame is received correctly.
4. Frame 0x81 with stop bit low, line held low 20 bit times, then high, then frame 0x3C -> exactly one frame_err, rx_data stays at previous value (0 after reset), then rx_valid with rx_data=0x3C.
5. rst asserted 1 CLK during data bit 4 of frame 0xFF -> all outputs 0 next cycle, state IDLE, no pulse. The next frame 0x12 (sent after idle >= 1 bit) is received as 0x12.
6. os_tick held low while rx toggles for 100 CLK in IDLE -> busy, rx_valid, frame_err stay 0; the resumed frame 0xC9 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 16x-oversampled 8N1 UART receiver: 2-FF input synchronizer, mid-bit start validation,
// centre-of-bit data sampling, stop-bit check with one-cycle valid / framing-error pulses.
module uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int OS        = 16
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 os_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int OS_W  = $clog2(OS);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [OS_W-1:0]  C_HALF_LAST = OS_W'(OS / 2 - 1);
  localparam logic [OS_W-1:0]  C_BIT_LAST  = OS_W'(OS - 1);
  localparam logic [BIT_W-1:0] C_IDX_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  logic                 r_sync_meta;
  logic                 r_rx_s;
  state_t               r_state;
  logic [OS_W-1:0]      r_os_cnt;
  logic [BIT_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;

  state_t               w_state_nxt;
  logic [OS_W-1:0]      w_os_cnt_nxt;
  logic [BIT_W-1:0]     w_bit_idx_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [DATA_BITS-1:0] w_rx_data_nxt;
  logic                 w_rx_valid_nxt;
  logic                 w_frame_err_nxt;

  // Both synchronizer flops reset to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_sync_meta <= 1'b1;
      r_rx_s      <= 1'b1;
    end else begin
      r_sync_meta <= rx;
      r_rx_s      <= r_sync_meta;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state     <= IDLE;
      r_os_cnt    <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_os_cnt    <= w_os_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first, so no path through this block can infer a latch.
    w_state_nxt     = r_state;
    w_os_cnt_nxt    = r_os_cnt;
    w_bit_idx_nxt   = r_bit_idx;
    w_shift_nxt     = r_shift;
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;

    if (os_tick) begin
      case (r_state)
        IDLE: begin
          if (!r_rx_s) begin
            w_state_nxt  = START;
            w_os_cnt_nxt = '0;
          end
        end

        START: begin
          if (r_os_cnt != C_HALF_LAST) begin
            w_os_cnt_nxt = r_os_cnt + OS_W'(1);
          end else if (!r_rx_s) begin
            w_state_nxt   = DATA;
            w_os_cnt_nxt  = '0;
            w_bit_idx_nxt = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end

        DATA: begin
          if (r_os_cnt != C_BIT_LAST) begin
            w_os_cnt_nxt = r_os_cnt + OS_W'(1);
          end else begin
            // Line order is LSB first, so shifting right leaves bit 0 in place after the last bit.
            if (DATA_BITS > 1) begin
              w_shift_nxt = {r_rx_s, r_shift[DATA_BITS-1:1]};
            end else begin
              w_shift_nxt = DATA_BITS'(r_rx_s);
            end
            w_os_cnt_nxt = '0;
            if (r_bit_idx == C_IDX_LAST) begin
              w_state_nxt = STOP;
            end else begin
              w_bit_idx_nxt = r_bit_idx + BIT_W'(1);
            end
          end
        end

        STOP: begin
          if (r_os_cnt != C_BIT_LAST) begin
            w_os_cnt_nxt = r_os_cnt + OS_W'(1);
          end else if (r_rx_s) begin
            w_rx_data_nxt  = r_shift;
            w_rx_valid_nxt = 1'b1;
            w_state_nxt    = IDLE;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = BREAK;
          end
        end

        BREAK: begin
          // A line held low after a bad stop bit must go high before a new start is accepted.
          if (r_rx_s) begin
            w_state_nxt = IDLE;
          end
        end

        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected bytes/errors into a queue,
// and a free-running monitor pops and compares on every rx_valid / frame_err pulse.
module tb_uart_rx;

  localparam int CLK_PER_TICK = 4;
  localparam int TICKS_PER_BIT = 16;
  localparam int BIT_CLKS = CLK_PER_TICK * TICKS_PER_BIT;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic       CLK;
  logic       rst;
  logic       os_tick;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  logic       tick_en;
  exp_t       sb_q[$];
  int         n_tests;
  int         n_fail;

  uart_rx #(
    .DATA_BITS(8),
    .OS       (16)
  ) dut (
    .CLK      (CLK),
    .rst      (rst),
    .os_tick  (os_tick),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One os_tick pulse every CLK_PER_TICK cycles while enabled; driven on the falling edge.
  initial begin
    logic [1:0] div;
    div     = '0;
    os_tick = 1'b0;
    forever begin
      @(negedge CLK);
      if (tick_en) begin
        div     = div + 2'd1;
        os_tick = (div == 2'd3);
      end else begin
        os_tick = 1'b0;
      end
    end
  end

  // Monitor: every output pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!rst && (rx_valid || frame_err)) begin
        check("valid_and_err_exclusive", 32'(rx_valid & frame_err), 32'd0);
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pulse: got valid=%0b err=%0b data=0x%0h, expected no pulse (t=%0t)",
                   rx_valid, frame_err, rx_data, $time);
        end else begin
          e = sb_q.pop_front();
          check("pulse_kind_err", 32'(frame_err), 32'(e.is_err));
          check("rx_data", 32'(rx_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push_exp(input logic is_err, input logic [7:0] data);
    exp_t e;
    e.is_err = is_err;
    e.data   = data;
    sb_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      wait_clks(BIT_CLKS);
    end
    rx = stop;
    wait_clks(BIT_CLKS);
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b1;
    wait_clks(n);
    rst = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rx      = 1'b1;
    tick_en = 1'b1;
    rst     = 1'b1;

    // Reset state
    wait_clks(3);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    wait_clks(BIT_CLKS);

    // 1: single frame
    push_exp(1'b0, 8'h55);
    send_frame(8'h55, 1'b1);
    wait_clks(BIT_CLKS);
    check("t1_busy_after_stop", 32'(busy), 32'd0);
    check("t1_sb_empty", 32'(sb_q.size()), 32'd0);

    // 2: back-to-back frames with no idle gap
    push_exp(1'b0, 8'hA3);
    push_exp(1'b0, 8'h0F);
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    wait_clks(BIT_CLKS);
    check("t2_sb_empty", 32'(sb_q.size()), 32'd0);
    check("t2_busy_idle", 32'(busy), 32'd0);

    // 3: short start glitch rejected, then a good frame
    rx = 1'b0;
    wait_clks(4 * CLK_PER_TICK);
    rx = 1'b1;
    wait_clks(2 * CLK_PER_TICK);
    check("t3_busy_during_glitch", 32'(busy), 32'd1);
    wait_clks(9 * CLK_PER_TICK);
    check("t3_busy_after_glitch", 32'(busy), 32'd0);
    wait_clks(BIT_CLKS);
    push_exp(1'b0, 8'h7E);
    send_frame(8'h7E, 1'b1);
    wait_clks(BIT_CLKS);
    check("t3_sb_empty", 32'(sb_q.size()), 32'd0);

    // 4: framing error from reset state, line held low, then recovery
    pulse_reset(1);
    wait_clks(2);
    check("t4_rx_data_cleared", 32'(rx_data), 32'h00);
    wait_clks(BIT_CLKS);
    push_exp(1'b1, 8'h00);
    send_frame(8'h81, 1'b0);
    wait_clks(20 * BIT_CLKS - BIT_CLKS);
    check("t4_busy_in_break", 32'(busy), 32'd1);
    check("t4_sb_after_err", 32'(sb_q.size()), 32'd0);
    rx = 1'b1;
    wait_clks(BIT_CLKS);
    check("t4_busy_after_break", 32'(busy), 32'd0);
    push_exp(1'b0, 8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_clks(BIT_CLKS);
    check("t4_sb_empty", 32'(sb_q.size()), 32'd0);

    // 5: reset during data bit 4 discards the frame
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    rx = 1'b1;
    wait_clks(4 * BIT_CLKS + BIT_CLKS / 2);
    check("t5_busy_mid_frame", 32'(busy), 32'd1);
    pulse_reset(1);
    check("t5_rx_data_after_rst", 32'(rx_data), 32'h00);
    check("t5_rx_valid_after_rst", 32'(rx_valid), 32'd0);
    check("t5_frame_err_after_rst", 32'(frame_err), 32'd0);
    check("t5_busy_after_rst", 32'(busy), 32'd0);
    wait_clks(4 * BIT_CLKS + BIT_CLKS / 2);
    check("t5_no_pulse", 32'(sb_q.size()), 32'd0);
    wait_clks(BIT_CLKS);
    push_exp(1'b0, 8'h12);
    send_frame(8'h12, 1'b1);
    wait_clks(BIT_CLKS);
    check("t5_sb_empty", 32'(sb_q.size()), 32'd0);

    // 6: no os_tick, rx toggling: nothing may happen
    tick_en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      rx = (i % 3 == 0) ? 1'b0 : ~rx;
      @(negedge CLK);
      if (busy !== 1'b0 || rx_valid !== 1'b0 || frame_err !== 1'b0) begin
        check("t6_quiet_no_tick", {29'd0, busy, rx_valid, frame_err}, 32'd0);
      end
    end
    check("t6_busy_no_tick", 32'(busy), 32'd0);
    rx = 1'b1;
    wait_clks(4);
    tick_en = 1'b1;
    wait_clks(BIT_CLKS);
    push_exp(1'b0, 8'hC9);
    send_frame(8'hC9, 1'b1);
    wait_clks(BIT_CLKS);
    check("t6_sb_empty", 32'(sb_q.size()), 32'd0);
    check("final_rx_data", 32'(rx_data), 32'hC9);
    check("final_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
